// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller/sequencer: six-state one-hot ring counter clocked on the
// falling edge, with a combinational control-word decoder and a halt latch.
module sap_1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [3:0]  Opcode,
    output logic [11:0] CON,
    output logic [5:0]  T,
    output logic        Hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    // {Cp, Ep, LmN, CEN, LiN, EiN, LaN, Ea, Su, Eu, LbN, LoN}
    localparam logic [11:0] CW_IDLE  = 12'h3E3;
    localparam logic [11:0] CW_PC_MA = 12'h5E3;
    localparam logic [11:0] CW_PC_UP = 12'hBE3;
    localparam logic [11:0] CW_IR_LD = 12'h263;
    localparam logic [11:0] CW_IR_MA = 12'h1A3;
    localparam logic [11:0] CW_A_LD  = 12'h2C3;
    localparam logic [11:0] CW_B_LD  = 12'h2E1;
    localparam logic [11:0] CW_ADD   = 12'h3C7;
    localparam logic [11:0] CW_SUB   = 12'h3CF;
    localparam logic [11:0] CW_OUT   = 12'h3F2;

    state_t state;
    state_t state_nxt;
    logic   hlt_nxt;

    always_ff @(negedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= T1;
            Hlt   <= 1'b0;
        end else begin
            state <= state_nxt;
            Hlt   <= hlt_nxt;
        end
    end

    // Any non-one-hot encoding falls through to T1.
    always_comb begin
        state_nxt = T1;
        hlt_nxt   = Hlt;
        if (Hlt) begin
            state_nxt = state;
        end else begin
            case (state)
                T1: state_nxt = T2;
                T2: state_nxt = T3;
                T3: state_nxt = T4;
                T4: begin
                    if (Opcode == OP_HLT) begin
                        state_nxt = T4;
                        hlt_nxt   = 1'b1;
                    end else begin
                        state_nxt = T5;
                    end
                end
                T5: state_nxt = T6;
                T6: state_nxt = T1;
                default: state_nxt = T1;
            endcase
        end
    end

    always_comb begin
        CON = CW_IDLE;
        if (!Hlt) begin
            unique case (1'b1)
                state[0]: CON = CW_PC_MA;
                state[1]: CON = CW_PC_UP;
                state[2]: CON = CW_IR_LD;
                state[3]: begin
                    case (Opcode)
                        OP_LDA:  CON = CW_IR_MA;
                        OP_ADD:  CON = CW_IR_MA;
                        OP_SUB:  CON = CW_IR_MA;
                        OP_OUT:  CON = CW_OUT;
                        default: CON = CW_IDLE;
                    endcase
                end
                state[4]: begin
                    case (Opcode)
                        OP_LDA:  CON = CW_A_LD;
                        OP_ADD:  CON = CW_B_LD;
                        OP_SUB:  CON = CW_B_LD;
                        default: CON = CW_IDLE;
                    endcase
                end
                state[5]: begin
                    case (Opcode)
                        OP_ADD:  CON = CW_ADD;
                        OP_SUB:  CON = CW_SUB;
                        default: CON = CW_IDLE;
                    endcase
                end
                default: CON = CW_IDLE;
            endcase
        end
    end

    assign T = state;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Bench for the SAP-1 sequencer: fixed vector table, hand-written reset and
// halt sequences, then random opcodes checked against a step/halt model.
module tb_sap_1_controller_sequencer;

    logic        Clk;
    logic        Clr;
    logic [3:0]  Opcode;
    logic [11:0] CON;
    logic [5:0]  T;
    logic        Hlt;

    int pass_cnt = 0;
    int total_cnt = 0;

    sap_1_controller_sequencer dut (
        .Clk(Clk),
        .Clr(Clr),
        .Opcode(Opcode),
        .CON(CON),
        .T(T),
        .Hlt(Hlt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not reach summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         clr;
        logic [3:0] op;
        logic [5:0] t;
        logic [11:0] con;
        logic       hlt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit c, input logic [3:0] o, input logic [5:0] t,
                       input logic [11:0] cw, input logic h);
        vec_t v;
        v.clr = c; v.op = o; v.t = t; v.con = cw; v.hlt = h;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic chk_invariants(input string tag);
        int drivers;
        drivers = int'(CON[10]) + int'(!CON[6]) + int'(CON[4]) + int'(CON[2]);
        chk({tag, " onehot"}, 12'($onehot(T)), 12'd1);
        chk({tag, " cp_ep"}, 12'(CON[11] & CON[10]), 12'd0);
        chk({tag, " bus"}, 12'(drivers <= 1), 12'd1);
    endtask

    // Reference: step 0..5 stands for T1..T6, expected words straight from
    // the instruction table.
    function automatic logic [11:0] ref_con(int step, logic [3:0] op, bit halted);
        logic [11:0] lda[3];
        logic [11:0] add_w[3];
        logic [11:0] sub_w[3];
        logic [11:0] out_w[3];
        lda   = '{12'h1A3, 12'h2C3, 12'h3E3};
        add_w = '{12'h1A3, 12'h2E1, 12'h3C7};
        sub_w = '{12'h1A3, 12'h2E1, 12'h3CF};
        out_w = '{12'h3F2, 12'h3E3, 12'h3E3};
        if (halted) return 12'h3E3;
        if (step == 0) return 12'h5E3;
        if (step == 1) return 12'hBE3;
        if (step == 2) return 12'h263;
        case (op)
            4'h0: return lda[step-3];
            4'h1: return add_w[step-3];
            4'h2: return sub_w[step-3];
            4'hE: return out_w[step-3];
            default: return 12'h3E3;
        endcase
    endfunction

    initial begin
        int step;
        bit halted;
        logic [3:0] cur_op;
        bit do_clr;
        logic [5:0] exp_t;

        Clr = 1'b1;
        Opcode = 4'h0;
        #2;
        chk("reset T", 12'(T), 12'h001);
        chk("reset CON", CON, 12'h5E3);
        chk("reset Hlt", 12'(Hlt), 12'h000);

        // LDA ring
        add(1, 4'h0, 6'h01, 12'h5E3, 0);
        add(0, 4'h0, 6'h02, 12'hBE3, 0);
        add(0, 4'h0, 6'h04, 12'h263, 0);
        add(0, 4'h0, 6'h08, 12'h1A3, 0);
        add(0, 4'h0, 6'h10, 12'h2C3, 0);
        add(0, 4'h0, 6'h20, 12'h3E3, 0);
        add(0, 4'h2, 6'h01, 12'h5E3, 0);
        // SUB, fetch words independent of opcode
        add(0, 4'h7, 6'h02, 12'hBE3, 0);
        add(0, 4'hF, 6'h04, 12'h263, 0);
        add(0, 4'h2, 6'h08, 12'h1A3, 0);
        add(0, 4'h2, 6'h10, 12'h2E1, 0);
        add(0, 4'h2, 6'h20, 12'h3CF, 0);
        // ADD
        add(1, 4'h1, 6'h01, 12'h5E3, 0);
        add(0, 4'h1, 6'h02, 12'hBE3, 0);
        add(0, 4'h1, 6'h04, 12'h263, 0);
        add(0, 4'h1, 6'h08, 12'h1A3, 0);
        add(0, 4'h1, 6'h10, 12'h2E1, 0);
        add(0, 4'h1, 6'h20, 12'h3C7, 0);
        // NOP (unlisted opcode)
        add(0, 4'h5, 6'h01, 12'h5E3, 0);
        add(0, 4'h5, 6'h02, 12'hBE3, 0);
        add(0, 4'h5, 6'h04, 12'h263, 0);
        add(0, 4'h5, 6'h08, 12'h3E3, 0);
        add(0, 4'h5, 6'h10, 12'h3E3, 0);
        add(0, 4'h5, 6'h20, 12'h3E3, 0);
        // OUT
        add(0, 4'hE, 6'h01, 12'h5E3, 0);
        add(0, 4'hE, 6'h02, 12'hBE3, 0);
        add(0, 4'hE, 6'h04, 12'h263, 0);
        add(0, 4'hE, 6'h08, 12'h3F2, 0);
        add(0, 4'hE, 6'h10, 12'h3E3, 0);
        add(0, 4'hE, 6'h20, 12'h3E3, 0);
        // HLT
        add(1, 4'hF, 6'h01, 12'h5E3, 0);
        add(0, 4'hF, 6'h02, 12'hBE3, 0);
        add(0, 4'hF, 6'h04, 12'h263, 0);
        add(0, 4'hF, 6'h08, 12'h3E3, 0);
        add(0, 4'hF, 6'h08, 12'h3E3, 1);
        add(0, 4'h0, 6'h08, 12'h3E3, 1);
        add(0, 4'hE, 6'h08, 12'h3E3, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge Clk);
            Opcode = vecs[i].op;
            Clr = vecs[i].clr;
            #1;
            chk($sformatf("vec%0d T", i), 12'(T), 12'(vecs[i].t));
            chk($sformatf("vec%0d CON", i), CON, vecs[i].con);
            chk($sformatf("vec%0d Hlt", i), 12'(Hlt), 12'(vecs[i].hlt));
            chk($sformatf("vec%0d Su", i), 12'(CON[3]),
                12'(vecs[i].con == 12'h3CF));
            Clr = 1'b0;
        end

        // Stays halted for 20 edges with opcode toggling
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            Opcode = 4'($urandom);
            #1;
            chk("halt T", 12'(T), 12'h008);
            chk("halt CON", CON, 12'h3E3);
            chk("halt Hlt", 12'(Hlt), 12'h001);
        end

        // Clr while halted
        @(posedge Clk);
        Clr = 1'b1;
        #1;
        chk("clr halted T", 12'(T), 12'h001);
        chk("clr halted Hlt", 12'(Hlt), 12'h000);
        Clr = 1'b0;
        @(posedge Clk);
        #1;
        chk("resume T2", 12'(T), 12'h002);

        // Clr mid-ADD at T5
        Opcode = 4'h1;
        @(posedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("add T5 T", 12'(T), 12'h010);
        chk("add T5 CON", CON, 12'h2E1);
        #2;
        Clr = 1'b1;
        #1;
        chk("abort T", 12'(T), 12'h001);
        chk("abort CON", CON, 12'h5E3);
        chk("abort Hlt", 12'(Hlt), 12'h000);
        @(posedge Clk);
        #1;
        chk("clr held T", 12'(T), 12'h001);
        Clr = 1'b0;
        @(posedge Clk);
        #1;
        chk("after abort T", 12'(T), 12'h002);
        chk("after abort CON", CON, 12'hBE3);

        // Random opcodes against the model
        step = 0;
        halted = 0;
        cur_op = 4'h0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge Clk);
            if (i > 0 && !halted) begin
                if (step == 3 && cur_op == 4'hF) halted = 1;
                else step = (step + 1) % 6;
            end
            cur_op = 4'($urandom);
            do_clr = (i == 0) || ($urandom_range(0, 49) == 0);
            Opcode = cur_op;
            Clr = do_clr;
            if (do_clr) begin
                step = 0;
                halted = 0;
            end
            #1;
            exp_t = 6'b000001 << step;
            chk("rand T", 12'(T), 12'(exp_t));
            chk("rand CON", CON, ref_con(step, cur_op, halted));
            chk("rand Hlt", 12'(Hlt), 12'(halted));
            chk_invariants("rand");
            Clr = 1'b0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
